// File: rtl/cpu_sequencer_pkg.sv
// Shared types and defaults for the multi-cycle CPU sequencer.
// Holds the state encodings, reset PC and wait-timeout defaults.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    IWAIT    = 3'd1,
    DECODE   = 3'd2,
    MEM_REQ  = 3'd3,
    MEM_WAIT = 3'd4,
    WB       = 3'd5,
    HALT     = 3'd7
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          TIMEOUT_DEF  = 256;

  // States that wait on an external handshake and so run the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == FETCH) || (s == IWAIT) ||
           (s == MEM_REQ) || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Clearable saturating wait counter with timeout compare.
// expired_o flags the last allowed cycle of a wait state.
module wait_timer
  import cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over count; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/memory/writeback sequencer.
// Moore strobes decode from state; ir_we follows the imem response.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  output logic        ir_we,
  input  logic        ebreak_flag,
  input  logic        is_load,
  input  logic        is_store,
  output logic        dmem_req_valid,
  output logic        dmem_req_we,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        rf_we,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [63:0] instret
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pc_q;
  logic [63:0] instret_q;
  logic        halted_q;
  logic        err_q;
  logic        store_q;
  logic        err_set;
  logic        expired;
  logic        tmr_clr;
  logic        tmr_en;

  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = is_wait_state(state_q);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (expired)
  );

  // Next-state selection; handshakes win over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (imem_req_ready) begin
          state_d = IWAIT;
        end else if (expired) begin
          state_d = HALT;
          err_set = 1'b1;
        end
      end
      IWAIT: begin
        if (imem_rsp_valid) begin
          state_d = DECODE;
        end else if (expired) begin
          state_d = HALT;
          err_set = 1'b1;
        end
      end
      DECODE: begin
        if (ebreak_flag) begin
          state_d = HALT;
        end else if (is_load && is_store) begin
          state_d = HALT;
          err_set = 1'b1;
        end else if (is_load || is_store) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end
      MEM_REQ: begin
        if (dmem_req_ready) begin
          state_d = MEM_WAIT;
        end else if (expired) begin
          state_d = HALT;
          err_set = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d = WB;
        end else if (expired) begin
          state_d = HALT;
          err_set = 1'b1;
        end
      end
      WB: begin
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
        err_set = 1'b1;
      end
    endcase
  end

  // Architectural state: FSM, PC, retire count, sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        store_q <= is_store;
      end
      if (state_q == WB) begin
        pc_q      <= next_pc;
        instret_q <= instret_q + 64'd1;
      end
      if (state_d == HALT) begin
        halted_q <= 1'b1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign imem_req_valid = !rst && (state_q == FETCH);
  assign ir_we          = !rst && (state_q == IWAIT) && imem_rsp_valid;
  assign dmem_req_valid = !rst && (state_q == MEM_REQ);
  assign dmem_req_we    = !rst && (state_q == MEM_REQ) && store_q;
  assign rf_we          = !rst && (state_q == WB) && !store_q;

  assign pc      = pc_q;
  assign instret = instret_q;
  assign halted  = halted_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 256: maximum cycles spent in one memory wait state.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-004 imem_req_valid  output  1   instruction fetch request
REQ-005 imem_req_ready  input   1   imem accepts request
REQ-006 imem_rsp_valid  input   1   instruction word valid this cycle
REQ-007 ir_we           output  1   latch instruction register
REQ-008 ebreak_flag     input   1   from decode, valid in DECODE
REQ-009 is_load         input   1   from decode, valid in DECODE
REQ-010 is_store        input   1   from decode, valid in DECODE
REQ-011 dmem_req_valid  output  1   data memory request
REQ-012 dmem_req_we     output  1   1 = store, 0 = load
REQ-013 dmem_req_ready  input   1   dmem accepts request
REQ-014 dmem_rsp_valid  input   1   load data / store ack valid
REQ-015 next_pc         input   32  PC computed by datapath
REQ-016 pc              output  32  current PC (registered)
REQ-017 rf_we           output  1   register file write strobe
REQ-018 halted          output  1   sticky; set on ebreak or error
REQ-019 err             output  1   sticky; timeout or load+store conflict
REQ-020 state           output  3   current FSM state encoding
REQ-021 instret         output  64  retired instruction count

Function
REQ-022 FSM states and encodings SHALL be FETCH=0, IWAIT=1, DECODE=2, MEM_REQ=3, MEM_WAIT=4, WB=5, HALT=7.
REQ-023 In FETCH, imem_req_valid=1, held until imem_req_ready is sampled high; that handshake SHALL move the FSM to IWAIT.
REQ-024 In IWAIT, imem_rsp_valid SHALL assert ir_we combinationally in that cycle and move the FSM to DECODE.
REQ-025 In DECODE, priority SHALL be: ebreak_flag -> HALT with halted=1; else is_load&is_store -> HALT with err=1; else load|store -> MEM_REQ; else -> WB.
REQ-026 In MEM_REQ, dmem_req_valid=1 and dmem_req_we=is_store, held until dmem_req_ready; the handshake SHALL move the FSM to MEM_WAIT.
REQ-027 In MEM_WAIT, dmem_rsp_valid SHALL move the FSM to WB.
REQ-028 In WB, pc_we is internal: pc <= next_pc, rf_we=1 unless the latched is_store is set, instret+1, next state FETCH.
REQ-029 The is_store value sampled in DECODE SHALL be latched for use in MEM_REQ and WB.
REQ-030 All strobes except ir_we SHALL be Moore outputs decoded from the state only.
REQ-031 Latency SHALL be 4 cycles per non-memory instruction and 6 cycles per load/store with zero-wait memories.
REQ-032 The wait counter SHALL clear on every state change and increment each cycle in FETCH, IWAIT, MEM_REQ and MEM_WAIT.
REQ-033 When the wait counter reaches TIMEOUT-1 without a handshake, the FSM SHALL go to HALT with err=1.
REQ-034 HALT SHALL be absorbing until rst; all strobes are 0 and pc is frozen.
REQ-035 Responses arriving in a state that is not waiting for them (e.g. imem_rsp_valid in FETCH) SHALL be ignored.
REQ-036 instret SHALL wrap modulo 2^64.

Reset
REQ-037 On rst, state=FETCH, pc=RESET_PC, halted=0, err=0, instret=0, wait counter=0, all strobes 0.
REQ-038 rst SHALL dominate any same-cycle handshake and any in-flight memory transaction; late responses after reset are dropped per REQ-035.

Structure
REQ-039 A shared package SHALL hold the state enum/encodings, the RESET_PC default and the TIMEOUT default.
REQ-040 One sub-module, wait_timer, SHALL implement the clearable saturating counter and the timeout compare.

Verification
REQ-041 Zero-wait addi at 0x8000_0000 with next_pc=0x8000_0004 -> rf_we for 1 cycle at cycle 4, pc=0x8000_0004, instret=1.
REQ-042 Store with dmem_req_ready delayed 3 cycles -> dmem_req_valid high for 4 cycles, dmem_req_we=1, rf_we never asserted, 6+3 cycles total.
REQ-043 ebreak in DECODE -> halted=1 next cycle, pc unchanged, no further imem_req_valid for 20 cycles.
REQ-044 imem_rsp_valid withheld in IWAIT -> err=1 and halted=1 after 256 cycles, state=7.
REQ-045 rst asserted in MEM_WAIT with dmem_rsp_valid high the same cycle -> state=FETCH, pc=RESET_PC, instret=0, no rf_we.
REQ-046 is_load=is_store=1 in DECODE -> err=1, no dmem_req_valid.
